// File: rtl/mem_access_ctrl.sv
// Word-access sequencer between the datapath request port and main memory.
// Holds each memory strobe for LATENCY cycles, then issues a one-cycle response.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    wait_cnt, cnt_nx;
  logic                wr_q;
  logic                accept;
  logic                misaligned;
  logic                wr_nx;
  logic                memread_nx, memwrite_nx;
  logic                resp_valid_nx, resp_err_nx;
  logic [DATA_W-1:0]   resp_rdata_nx;

  // Ready is a pure decode so a held request is taken on the first IDLE cycle.
  assign req_ready  = (state == S_IDLE) && !reset;
  assign misaligned = (req_addr[1:0] != 2'b00);

  // Next-state, counter and next values of the registered outputs.
  always_comb begin
    state_nx      = state;
    cnt_nx        = wait_cnt;
    accept        = 1'b0;
    resp_err_nx   = 1'b0;
    resp_rdata_nx = '0;

    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (misaligned) begin
            state_nx    = S_RESP;
            resp_err_nx = 1'b1;
          end else begin
            state_nx = S_ACCESS;
            cnt_nx   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_ACCESS: begin
        if (wait_cnt == '0) begin
          state_nx = S_RESP;
          // Capture the word on the edge that ends the last strobe cycle.
          if (!wr_q) begin
            resp_rdata_nx = data_out;
          end
        end else begin
          cnt_nx = wait_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase

    wr_nx         = accept ? req_write : wr_q;
    memread_nx    = (state_nx == S_ACCESS) && !wr_nx;
    memwrite_nx   = (state_nx == S_ACCESS) && wr_nx;
    resp_valid_nx = (state_nx == S_RESP);
  end

  // State, counter, request holding registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      wr_q       <= 1'b0;
      address    <= '0;
      data_in    <= '0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= cnt_nx;
      memread    <= memread_nx;
      memwrite   <= memwrite_nx;
      resp_valid <= resp_valid_nx;
      resp_err   <= resp_err_nx;
      resp_rdata <= resp_rdata_nx;
      if (accept) begin
        wr_q    <= req_write;
        address <= req_addr;
        data_in <= req_wdata;
      end
    end
  end

endmodule
